// File: rtl/shot_slot_scheduler_pkg.sv
// Shared definitions for the shot slot scheduler and the debug display.
// Holds the default slot count, the default launch spacing in frames, the
// field widths used on the scheduler ports, and the scheduler state enum.
package shot_slot_scheduler_pkg;

  localparam int NUM_OF_SHOTS    = 8;
  localparam int COOLDOWN_FRAMES = 6;   // legal range 1..15

  localparam int IDX_W   = 3;           // launchIdx width
  localparam int CNT_W   = 4;           // cooldown counter width
  localparam int FREE_W  = 4;           // freeCount width
  localparam int FIRED_W = 8;           // shotsFired width

  typedef enum logic [1:0] {
    ST_READY    = 2'd0,
    ST_LAUNCH   = 2'd1,
    ST_COOLDOWN = 2'd2
  } shot_state_e;

endpackage

// File: rtl/shot_slot_scheduler_if.sv
// Bundle between the game logic and the shot slot scheduler.
// master: game side (frame pulse, enable, fire button, per-slot hit and
//         off-screen flags in; occupancy, launch pulse/index, counters out)
// slave : the scheduler itself
interface shot_slot_scheduler_if #(
  parameter int NUM_OF_SHOTS = shot_slot_scheduler_pkg::NUM_OF_SHOTS
);
  logic                    startOfFrame;
  logic                    enable;
  logic                    fireReq;
  logic [NUM_OF_SHOTS-1:0] hitPulse_shots;
  logic [NUM_OF_SHOTS-1:0] offScreen;
  logic [NUM_OF_SHOTS-1:0] shotActive;
  logic [NUM_OF_SHOTS-1:0] launchPulse;
  logic [2:0]              launchIdx;
  logic [3:0]              freeCount;
  logic [7:0]              shotsFired;

  modport master (
    output startOfFrame, enable, fireReq, hitPulse_shots, offScreen,
    input  shotActive, launchPulse, launchIdx, freeCount, shotsFired
  );

  modport slave (
    input  startOfFrame, enable, fireReq, hitPulse_shots, offScreen,
    output shotActive, launchPulse, launchIdx, freeCount, shotsFired
  );
endinterface

// File: rtl/shot_slot_scheduler_prio_enc.sv
// Lowest-index-first priority encoder for free shot slots.
// free_i  : one bit per slot, 1 = slot may be allocated
// idx_o   : index of the lowest set bit of free_i (0 when none)
// valid_o : at least one bit of free_i is set
module shot_slot_prio_enc #(
  parameter int NUM_OF_SHOTS = shot_slot_scheduler_pkg::NUM_OF_SHOTS
) (
  input  logic [NUM_OF_SHOTS-1:0]                 free_i,
  output logic [shot_slot_scheduler_pkg::IDX_W-1:0] idx_o,
  output logic                                    valid_o
);
  import shot_slot_scheduler_pkg::*;

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NUM_OF_SHOTS - 1; i >= 0; i--) begin
      if (free_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/shot_slot_scheduler.sv
// Shot slot scheduler: turns fire-button edges into slot launches, at most
// one launch per COOLDOWN_FRAMES+1 frames, and tracks slot occupancy.
// clk, resetN : system clock, asynchronous active-low reset
// bus (slave) : frame pulse, enable, fire, per-slot hit/off-screen in;
//               shotActive, launchPulse, launchIdx, freeCount, shotsFired out
//
// state       | meaning
// ST_READY    | waiting for a frame start with a pending request and a free slot
// ST_LAUNCH   | one cycle: launch pulse, index and occupancy of new shot visible
// ST_COOLDOWN | counting frame starts down to zero before accepting the next launch
module shot_slot_scheduler #(
  parameter int NUM_OF_SHOTS    = shot_slot_scheduler_pkg::NUM_OF_SHOTS,
  parameter int COOLDOWN_FRAMES = shot_slot_scheduler_pkg::COOLDOWN_FRAMES
) (
  input  logic                 clk,
  input  logic                 resetN,
  shot_slot_scheduler_if.slave bus
);
  import shot_slot_scheduler_pkg::*;

  shot_state_e             state_q, state_d;
  logic                    pending_q, pending_d;
  logic                    fire_prev_q;
  logic [NUM_OF_SHOTS-1:0] active_q, active_d;
  logic [NUM_OF_SHOTS-1:0] pulse_q, pulse_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [FIRED_W-1:0]      fired_q, fired_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        sel_idx;
  logic                    sel_valid;
  logic                    fire_edge;
  logic [NUM_OF_SHOTS-1:0] release_v;
  logic [FREE_W-1:0]       free_cnt;

  // Selection looks only at the registered occupancy, so a slot released
  // this cycle becomes eligible one cycle later.
  shot_slot_prio_enc #(.NUM_OF_SHOTS(NUM_OF_SHOTS)) u_prio_enc (
    .free_i  (~active_q),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  assign fire_edge = bus.fireReq & ~fire_prev_q;
  assign release_v = bus.hitPulse_shots | bus.offScreen;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_READY;
      pending_q   <= 1'b0;
      fire_prev_q <= 1'b0;
      active_q    <= '0;
      pulse_q     <= '0;
      idx_q       <= '0;
      fired_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      fire_prev_q <= bus.fireReq;
      active_q    <= active_d;
      pulse_q     <= pulse_d;
      idx_q       <= idx_d;
      fired_q     <= fired_d;
      cnt_q       <= cnt_d;
    end
  end

  // Launch results are registered on the READY->LAUNCH transition so that
  // pulse, index, occupancy and count all appear together during LAUNCH.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | fire_edge;
    active_d  = active_q & ~release_v;
    pulse_d   = '0;
    idx_d     = idx_q;
    fired_d   = fired_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_READY: begin
        if (bus.startOfFrame && pending_q && sel_valid) begin
          state_d           = ST_LAUNCH;
          pending_d         = fire_edge;
          active_d[sel_idx] = 1'b1;   // set after release: launch wins
          pulse_d[sel_idx]  = 1'b1;
          idx_d             = sel_idx;
          fired_d           = (fired_q == '1) ? fired_q : fired_q + 8'd1;
          cnt_d             = CNT_W'(COOLDOWN_FRAMES);
        end
      end
      ST_LAUNCH: state_d = ST_COOLDOWN;
      ST_COOLDOWN: begin
        if (cnt_q == '0) begin
          state_d = ST_READY;
        end else if (bus.startOfFrame) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_READY;
    endcase

    // Game not running: flush everything except the statistics.
    if (!bus.enable) begin
      state_d   = ST_READY;
      pending_d = 1'b0;
      active_d  = '0;
      pulse_d   = '0;
      cnt_d     = '0;
      idx_d     = idx_q;
      fired_d   = fired_q;
    end
  end

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < NUM_OF_SHOTS; i++) begin
      free_cnt = free_cnt + {3'b000, ~active_q[i]};
    end
  end

  assign bus.shotActive  = active_q;
  assign bus.launchPulse = pulse_q;
  assign bus.launchIdx   = idx_q;
  assign bus.freeCount   = free_cnt;
  assign bus.shotsFired  = fired_q;
endmodule

// File: tb/tb_shot_slot_scheduler.sv
module tb_shot_slot_scheduler;
  localparam int N  = 8;
  localparam int CD = 6;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  shot_slot_scheduler_if #(.NUM_OF_SHOTS(N)) bus();

  shot_slot_scheduler #(.NUM_OF_SHOTS(N), .COOLDOWN_FRAMES(CD)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: frame-count based cooldown, plain occupancy vector
  logic [N-1:0] m_active, m_pulse;
  logic [2:0]   m_idx;
  int           m_fired;
  bit           m_pending, m_fire_prev, m_cd;
  int           m_sof_cnt, m_last_sof;

  int cur_frame;
  int lf[$];
  int li[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = '0; m_pulse = '0; m_idx = '0; m_fired = 0;
    m_pending = 0; m_fire_prev = 0; m_cd = 0; m_last_sof = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] nxt;
    bit edge_v;
    int slot;
    edge_v = bus.fireReq && !m_fire_prev;
    m_fire_prev = bus.fireReq;
    if (bus.startOfFrame) m_sof_cnt++;
    if (!bus.enable) begin
      m_active = '0; m_pulse = '0; m_pending = 0; m_cd = 0;
      return;
    end
    nxt = m_active & ~(bus.hitPulse_shots | bus.offScreen);
    m_pulse = '0;
    slot = -1;
    for (int i = N - 1; i >= 0; i--) if (!m_active[i]) slot = i;
    if (bus.startOfFrame && m_pending && slot >= 0 &&
        (!m_cd || (m_sof_cnt - m_last_sof) > CD)) begin
      nxt[slot] = 1'b1;
      m_pulse[slot] = 1'b1;
      m_idx = 3'(slot);
      if (m_fired < 255) m_fired++;
      m_pending = edge_v;
      m_cd = 1;
      m_last_sof = m_sof_cnt;
    end else begin
      m_pending = m_pending | edge_v;
    end
    m_active = nxt;
  endtask

  task automatic check_outputs();
    chk("shotActive",  bus.shotActive,  m_active);
    chk("launchPulse", bus.launchPulse, m_pulse);
    chk("launchIdx",   bus.launchIdx,   m_idx);
    chk("shotsFired",  bus.shotsFired,  m_fired);
    chk("freeCount",   bus.freeCount,   N - $countones(m_active));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    if (bus.launchPulse != '0) begin
      lf.push_back(cur_frame);
      li.push_back(int'(bus.launchIdx));
    end
    bus.startOfFrame = 1'b0;
  endtask

  task automatic frame(input int len, input bit pf, input logic [N-1:0] rel,
                       input logic [N-1:0] hitv, input bit en_drop);
    cur_frame++;
    for (int c = 0; c < len; c++) begin
      bus.startOfFrame = (c == 0);
      if (pf) bus.fireReq = (c == 2);
      bus.offScreen = (c == 2) ? rel : '0;
      if (c == 0) bus.hitPulse_shots = '0;
      else if (c == 3) bus.hitPulse_shots = hitv;
      bus.enable = !(en_drop && c == 1);
      tick();
    end
  endtask

  task automatic do_reset();
    #2;
    resetN = 1'b0;
    #1;
    model_reset();
    chk("rst_shotActive",  bus.shotActive,  0);
    chk("rst_launchPulse", bus.launchPulse, 0);
    chk("rst_launchIdx",   bus.launchIdx,   0);
    chk("rst_shotsFired",  bus.shotsFired,  0);
    chk("rst_freeCount",   bus.freeCount,   N);
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic fill(input int n);
    for (int f = 0; f < 8 * n + 16 && $countones(bus.shotActive) < n; f++)
      frame(5, 1, '0, '0, 0);
    chk("fill_count", $countones(bus.shotActive), n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    bus.startOfFrame = 0; bus.enable = 1; bus.fireReq = 0;
    bus.hitPulse_shots = '0; bus.offScreen = '0;
    cur_frame = -1; m_sof_cnt = 0;
    do_reset();

    // first launch after reset
    bus.fireReq = 1; tick(); bus.fireReq = 0; tick();
    bus.startOfFrame = 1; tick();
    chk("first_pulse", bus.launchPulse, 8'h01);
    chk("first_idx",   bus.launchIdx,   0);
    chk("first_active", bus.shotActive, 8'h01);
    chk("first_fired", bus.shotsFired,  1);

    // reset during LAUNCH: pulse gone, nothing relaunched
    do_reset();
    chk("rst_mid_launch_pulse", bus.launchPulse, 0);
    lf.delete(); li.delete();
    repeat (2) frame(5, 0, '0, '0, 0);
    chk("rst_mid_launch_none", lf.size(), 0);

    // held fire button: one launch only
    do_reset();
    bus.fireReq = 1; tick();
    lf.delete(); li.delete();
    repeat (20) frame(5, 0, '0, '0, 0);
    chk("held_launches", lf.size(), 1);
    bus.fireReq = 0;

    // edges every frame: frames 0, 7, 14 into slots 0, 1, 2
    do_reset();
    bus.fireReq = 1; tick(); bus.fireReq = 0; tick();
    lf.delete(); li.delete(); cur_frame = -1;
    repeat (20) frame(5, 1, '0, '0, 0);
    chk("spaced_count", lf.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("spaced_frame", (lf.size() > k) ? lf[k] : -1, 7 * k);
      chk("spaced_slot",  (li.size() > k) ? li[k] : -1, k);
    end

    // all slots full, then free slot 3
    do_reset();
    fill(8);
    lf.delete(); li.delete();
    repeat (8) frame(5, 1, '0, '0, 0);
    chk("full_no_launch", lf.size(), 0);
    chk("full_active", bus.shotActive, 8'hFF);
    bus.offScreen = 8'h08; tick(); bus.offScreen = '0;
    chk("release3_active", bus.shotActive, 8'hF7);
    lf.delete(); li.delete();
    frame(5, 0, '0, '0, 0);
    chk("refill_count", lf.size(), 1);
    chk("refill_slot", (li.size() > 0) ? li[0] : -1, 3);
    chk("refill_active", bus.shotActive, 8'hFF);

    // hit release
    do_reset();
    fill(4);
    chk("pre_hit_active", bus.shotActive, 8'h0F);
    bus.hitPulse_shots = 8'h05; tick();
    chk("hit_active", bus.shotActive, 8'h0A);
    chk("hit_free", bus.freeCount, 6);
    tick();
    chk("hit_idempotent", bus.shotActive, 8'h0A);
    bus.hitPulse_shots = '0;

    // enable drop mid-cooldown
    do_reset();
    fill(6);
    bus.offScreen = 8'h03; tick(); bus.offScreen = '0;
    chk("pre_flush_active", bus.shotActive, 8'h3C);
    f0 = int'(bus.shotsFired);
    bus.enable = 0; tick(); bus.enable = 1;
    chk("flush_active", bus.shotActive, 0);
    chk("flush_fired", bus.shotsFired, f0);
    bus.fireReq = 1; tick(); bus.fireReq = 0;
    lf.delete(); li.delete();
    frame(5, 0, '0, '0, 0);
    chk("post_flush_launch", lf.size(), 1);
    chk("post_flush_slot", (li.size() > 0) ? li[0] : -1, 0);

    // saturation
    do_reset();
    lf.delete(); li.delete();
    for (int f = 0; f < 256 * 8 + 50 && lf.size() < 256; f++)
      frame(4, 1, 8'hFF, '0, 0);
    chk("sat_launches", lf.size(), 256);
    chk("sat_fired", bus.shotsFired, 255);
    lf.delete(); li.delete();

    // randomized traffic
    do_reset();
    for (int f = 0; f < 300; f++) begin
      logic [N-1:0] rel, hitv;
      rel  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      hitv = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 59) == 0) do_reset();
      frame($urandom_range(4, 7), 1'($urandom_range(0, 1)), rel, hitv,
            $urandom_range(0, 29) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/shot_slot_scheduler.md
SHOT_SLOT_SCHEDULER -- requirements
Module: shot_slot_scheduler

Interface
REQ-001 Parameter NUM_OF_SHOTS, default 8, number of shot object slots.
REQ-002 Parameter COOLDOWN_FRAMES, default 6, frames between consecutive launches (range 1..15).
REQ-003 clk  input  1  system clock.
REQ-004 resetN  input  1  asynchronous, active-low reset.
REQ-005 startOfFrame  input  1  one-cycle pulse at frame start.
REQ-006 enable  input  1  game-running qualifier; low flushes all shots.
REQ-007 fireReq  input  1  player fire button, level, already synchronised to clk.
REQ-008 hitPulse_shots  input  NUM_OF_SHOTS  per-slot hit flags from the bird/shot collision block, held high until the next startOfFrame.
REQ-009 offScreen  input  NUM_OF_SHOTS  per-slot flags from the shot objects, high while the shot is outside the visible area.
REQ-010 shotActive  output  NUM_OF_SHOTS  registered per-slot occupancy; drives the shot objects' enables.
REQ-011 launchPulse  output  NUM_OF_SHOTS  one-hot, one-cycle pulse that loads the start position into the selected slot.
REQ-012 launchIdx  output  3  index of the last launched slot, held until the next launch.
REQ-013 freeCount  output  4  number of clear bits in shotActive, combinational from the register.
REQ-014 shotsFired  output  8  launches since reset, saturating.

Function
REQ-015 Rising edge of fireReq (current high, previous cycle low) shall set the pending flag; holding fireReq shall never produce a second request.
REQ-016 FSM states: READY, LAUNCH, COOLDOWN.
REQ-017 READY -> LAUNCH on a startOfFrame cycle with pending=1, enable=1 and freeCount>0; otherwise the FSM stays in READY with pending kept.
REQ-018 LAUNCH lasts exactly one cycle. It selects the lowest-index slot whose registered shotActive bit is 0.
REQ-019 In LAUNCH, the scheduler sets shotActive[idx], asserts launchPulse[idx] for that cycle, loads launchIdx, clears pending, increments shotsFired, and loads the cooldown counter with COOLDOWN_FRAMES.
REQ-020 LAUNCH -> COOLDOWN unconditionally.
REQ-021 In COOLDOWN, the counter decrements on each startOfFrame. When the counter reaches 0, COOLDOWN -> READY takes effect on the next cycle.
REQ-022 A launch therefore occurs at most once per COOLDOWN_FRAMES+1 frames; the first possible launch is 1 cycle after a startOfFrame.
REQ-023 A fireReq edge during LAUNCH or COOLDOWN sets pending, which is served at the first eligible startOfFrame in READY.
REQ-024 Release: shotActive[i] shall clear on the cycle after hitPulse_shots[i] or offScreen[i] is sampled high; release is level-sensitive and idempotent.
REQ-025 Simultaneous release and launch on the same slot in the same cycle: launch wins and shotActive[i] stays 1.
REQ-026 A slot freed in cycle t is not eligible for allocation before cycle t+1.
REQ-027 All slots full at an eligible startOfFrame: no launch, FSM stays in READY, pending retained.
REQ-028 shotsFired shall saturate at 255 and not wrap.
REQ-029 enable low in any state: next cycle shotActive=0, launchPulse=0, pending=0, counter=0, FSM=READY.
REQ-030 While enable is low, shotsFired and launchIdx shall hold their values.

Reset
REQ-031 Asynchronous reset shall force FSM=READY, shotActive=0, launchPulse=0, launchIdx=0, shotsFired=0, counter=0, pending=0, and the fireReq history bit to 0.
REQ-032 Reset asserted mid-LAUNCH or mid-COOLDOWN shall abort the operation with no launchPulse after reset release.

Structure
REQ-033 A shared package shall hold NUM_OF_SHOTS, COOLDOWN_FRAMES, and the FSM state enum; the enum is shared with the debug display.
REQ-034 The lowest-free-slot selection shall be a separate combinational sub-module, shot_slot_prio_enc (input: free vector; outputs: index, valid).

Verification
REQ-035 Reset, enable=1, fireReq edge, then startOfFrame -> next cycle launchPulse=8'b0000_0001, launchIdx=0, shotActive=8'h01, shotsFired=1.
REQ-036 fireReq held high for 20 frames with COOLDOWN_FRAMES=6 -> exactly one launch.
REQ-037 Repeated fireReq edges every frame for 20 frames, COOLDOWN_FRAMES=6 -> launches in frames 0, 7, 14 only, into slots 0, 1, 2.
REQ-038 shotActive=8'hFF, fireReq edge, startOfFrame -> no launch. Then offScreen[3]=1 -> shotActive=8'hF7, and the next startOfFrame launches slot 3.
REQ-039 shotActive=8'h0F, hitPulse_shots=8'h05 -> shotActive=8'h0A one cycle later, freeCount=6.
REQ-040 Mid-COOLDOWN with shotActive=8'h3C, drop enable for 1 cycle -> shotActive=0 and FSM=READY; shotsFired unchanged.
REQ-041 256 launches -> shotsFired remains 255.
